// File: rtl/vga_timing_gen_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants for the VGA timing generator: default 640x480 timing,
// sync polarity encodings, default shadow-channel geometry and a helper that
// sums the four segments of a line or frame into its total length.
// -----------------------------------------------------------------------------
package vga_pkg;

    // Default 640x480 @ 60 Hz timing (pixel units / line units)
    localparam int DEF_H_ACTIVE = 32'd640;
    localparam int DEF_H_FP     = 32'd16;
    localparam int DEF_H_SYNC   = 32'd96;
    localparam int DEF_H_BP     = 32'd48;
    localparam int DEF_V_ACTIVE = 32'd480;
    localparam int DEF_V_FP     = 32'd10;
    localparam int DEF_V_SYNC   = 32'd2;
    localparam int DEF_V_BP     = 32'd33;
    localparam int DEF_CLK_DIV  = 32'd2;
    localparam int DEF_COORD_W  = 32'd10;

    // Shadowed host channels (main value plus player scores)
    localparam int DEF_NUM_CH   = 32'd5;
    localparam int DEF_CH_W     = 32'd16;

    // Active level of hsync/vsync
    localparam logic SYNC_NEG = 1'b0;
    localparam logic SYNC_POS = 1'b1;

    // Total length of a line or frame: active + front porch + sync + back porch
    function automatic int calc_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
// Host write bus into the shadow-value staging registers.
//   wr_en   : write strobe
//   wr_ch   : channel index (indices >= NUM_CH are ignored by the slave)
//   wr_data : value to stage
// master = host side, slave = timing generator side.
// -----------------------------------------------------------------------------
interface vga_timing_gen_if
    import vga_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = DEF_CH_W
);
    localparam int WCH_W = (NUM_CH > 32'd1) ? $clog2(NUM_CH) : 32'd1;

    logic             wr_en;
    logic [WCH_W-1:0] wr_ch;
    logic [CH_W-1:0]  wr_data;

    modport master (output wr_en, output wr_ch, output wr_data);
    modport slave  (input  wr_en, input  wr_ch, input  wr_data);
endinterface

// File: rtl/vga_shadow_regs.sv
// -----------------------------------------------------------------------------
// vga_shadow_regs
// Double buffer for NUM_CH host values. Host writes land in a staging bank;
// the whole bank is copied into the shadow bank on commit_tick (vblank start),
// so the display only ever sees values that are constant for a whole frame.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   commit_tick  : single-clk strobe, copy stage -> shadow on this edge
//   wr_en/wr_ch/wr_data : staging write (wr_ch >= NUM_CH ignored)
//   ch_data      : shadow bank, channel k at [k*CH_W +: CH_W]
//   commit       : registered one-clk pulse, same clk as ch_data updates
//   pending      : staging written since the last commit
// -----------------------------------------------------------------------------
module vga_shadow_regs
    import vga_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = DEF_CH_W,
    parameter int WCH_W  = 32'd3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   commit_tick,
    input  logic                   wr_en,
    input  logic [WCH_W-1:0]       wr_ch,
    input  logic [CH_W-1:0]        wr_data,
    output logic [NUM_CH*CH_W-1:0] ch_data,
    output logic                   commit,
    output logic                   pending
);
    // One extra bit so NUM_CH itself is representable for the range check
    localparam int                 LIM_W    = WCH_W + 32'd1;
    localparam logic [LIM_W-1:0]   CH_LIMIT = LIM_W'(NUM_CH);

    logic [CH_W-1:0] stage_r  [NUM_CH];
    logic [CH_W-1:0] shadow_r [NUM_CH];
    logic            commit_r;
    logic            pending_r;
    logic            wr_hit_s;

    // Write decode: only in-range channel indices touch the staging bank
    always_comb begin
        if (wr_en && ({1'b0, wr_ch} < CH_LIMIT)) begin
            wr_hit_s = 1'b1;
        end else begin
            wr_hit_s = 1'b0;
        end
    end

    // Stage/shadow banks, commit pulse and pending flag. Shadow samples the
    // pre-write stage, so a write on the commit edge waits for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                stage_r[k]  <= {CH_W{1'b0}};
                shadow_r[k] <= {CH_W{1'b0}};
            end
            commit_r  <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            if (commit_tick) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    shadow_r[k] <= stage_r[k];
                end
                commit_r <= 1'b1;
            end else begin
                commit_r <= 1'b0;
            end

            if (wr_hit_s) begin
                stage_r[wr_ch] <= wr_data;
                pending_r      <= 1'b1;
            end else if (commit_tick) begin
                pending_r      <= 1'b0;
            end else begin
                pending_r      <= pending_r;
            end
        end
    end

    // Flatten the shadow bank onto the output bus (wiring only)
    always_comb begin
        ch_data = {(NUM_CH*CH_W){1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            ch_data[k*CH_W +: CH_W] = shadow_r[k];
        end
    end

    assign commit  = commit_r;
    assign pending = pending_r;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA timing generator with frame-synchronous value shadowing.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   wr_bus (slave)         : host write bus into the staging registers
//   pix_en                 : one-clk pulse every CLK_DIV clks (pixel clock)
//   hsync, vsync           : sync outputs, active level SYNC_POL
//   active                 : inside the visible area
//   hcount, vcount         : current pixel position
//   line_start/frame_start : one-clk pulses on entering h=0 / (0,0)
//   ch_data, commit, pending : shadowed values, commit pulse, staging dirty
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter int   CLK_DIV  = DEF_CLK_DIV,
    parameter logic SYNC_POL = SYNC_NEG,
    parameter int   COORD_W  = DEF_COORD_W,
    parameter int   NUM_CH   = DEF_NUM_CH,
    parameter int   CH_W     = DEF_CH_W
) (
    input  logic                   clk,
    input  logic                   rst,
    vga_timing_gen_if.slave        wr_bus,
    output logic                   pix_en,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   active,
    output logic [COORD_W-1:0]     hcount,
    output logic [COORD_W-1:0]     vcount,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [NUM_CH*CH_W-1:0] ch_data,
    output logic                   commit,
    output logic                   pending
);
    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W   = (CLK_DIV > 32'd1) ? $clog2(CLK_DIV) : 32'd1;
    localparam int WCH_W   = (NUM_CH > 32'd1) ? $clog2(NUM_CH) : 32'd1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 32'd1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 32'd1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 32'd1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_BEG   = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG   = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [COORD_W-1:0] COORD_0  = {COORD_W{1'b0}};
    // Divider starts at 0, so with CLK_DIV == 1 pix_en is already high in reset
    localparam logic               PIX_EN_RST = (CLK_DIV == 32'd1);

    logic [DIV_W-1:0]   div_r, div_next_s;
    logic               pix_en_r;
    logic [COORD_W-1:0] h_r, v_r, h_next_s, v_next_s;
    logic               hsync_r, vsync_r, active_r;
    logic               line_start_r, frame_start_r;
    logic               commit_tick_s;

    // Divider next value: 0 .. CLK_DIV-1, wrapping
    always_comb begin
        if (div_r == DIV_LAST) begin
            div_next_s = {DIV_W{1'b0}};
        end else begin
            div_next_s = div_r + DIV_W'(1'b1);
        end
    end

    // Position the counters move to on the next pix_en edge
    always_comb begin
        if (h_r == H_LAST) begin
            h_next_s = COORD_0;
            if (v_r == V_LAST) begin
                v_next_s = COORD_0;
            end else begin
                v_next_s = v_r + COORD_W'(1'b1);
            end
        end else begin
            h_next_s = h_r + COORD_W'(1'b1);
            v_next_s = v_r;
        end
    end

    // Vblank start: the pix_en edge that lands on (0, V_ACTIVE)
    always_comb begin
        if (pix_en_r && (h_next_s == COORD_0) && (v_next_s == V_ACT)) begin
            commit_tick_s = 1'b1;
        end else begin
            commit_tick_s = 1'b0;
        end
    end

    // Divider, counters and decode. Decode uses the next position so the
    // registered flags always describe the hcount/vcount shown alongside them.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r         <= {DIV_W{1'b0}};
            pix_en_r      <= PIX_EN_RST;
            h_r           <= H_LAST;
            v_r           <= V_LAST;
            hsync_r       <= ~SYNC_POL;
            vsync_r       <= ~SYNC_POL;
            active_r      <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            div_r    <= div_next_s;
            pix_en_r <= (div_next_s == DIV_LAST);
            if (pix_en_r) begin
                h_r           <= h_next_s;
                v_r           <= v_next_s;
                active_r      <= (h_next_s < H_ACT) && (v_next_s < V_ACT);
                hsync_r       <= ((h_next_s >= HS_BEG) && (h_next_s < HS_END)) ? SYNC_POL : ~SYNC_POL;
                vsync_r       <= ((v_next_s >= VS_BEG) && (v_next_s < VS_END)) ? SYNC_POL : ~SYNC_POL;
                line_start_r  <= (h_next_s == COORD_0);
                frame_start_r <= (h_next_s == COORD_0) && (v_next_s == COORD_0);
            end else begin
                line_start_r  <= 1'b0;
                frame_start_r <= 1'b0;
            end
        end
    end

    vga_shadow_regs #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .WCH_W  (WCH_W)
    ) u_shadow (
        .clk         (clk),
        .rst         (rst),
        .commit_tick (commit_tick_s),
        .wr_en       (wr_bus.wr_en),
        .wr_ch       (wr_bus.wr_ch),
        .wr_data     (wr_bus.wr_data),
        .ch_data     (ch_data),
        .commit      (commit),
        .pending     (pending)
    );

    assign pix_en      = pix_en_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign active      = active_r;
    assign hcount      = h_r;
    assign vcount      = v_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;

endmodule
